// File: rtl/quad_encoder_array_if.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_array_if
// Description : Bundle of encoder pins and per-channel results exchanged
//               between quad_encoder_array and its environment.
//               master : drives raw encoder pins and error_clear
//               slave  : the encoder array itself
//               Optional QUAD_INDEX_EN adds index / index_seen.
// Revision    : 1.0 - initial release
// ============================================================================
interface quad_encoder_array_if #(
    parameter int CHANNELS    = 2,
    parameter int COUNT_WIDTH = 32
);
    logic [CHANNELS-1:0]             quadA;
    logic [CHANNELS-1:0]             quadB;
`ifdef QUAD_INDEX_EN
    logic [CHANNELS-1:0]             index;
    logic [CHANNELS-1:0]             index_seen;
`endif
    logic                            error_clear;
    logic [CHANNELS*COUNT_WIDTH-1:0] count;
    logic [CHANNELS*COUNT_WIDTH-1:0] velocity;
    logic                            vel_valid;
    logic [CHANNELS-1:0]             error;
    logic [CHANNELS-1:0]             A_filtered;

    modport master (
`ifdef QUAD_INDEX_EN
        output index,
        input  index_seen,
`endif
        output quadA,
        output quadB,
        output error_clear,
        input  count,
        input  velocity,
        input  vel_valid,
        input  error,
        input  A_filtered
    );

    modport slave (
`ifdef QUAD_INDEX_EN
        input  index,
        output index_seen,
`endif
        input  quadA,
        input  quadB,
        input  error_clear,
        output count,
        output velocity,
        output vel_valid,
        output error,
        output A_filtered
    );
endinterface
`default_nettype wire

// File: rtl/quad_encoder_array.sv
`default_nettype none
// ============================================================================
// Module      : quad_encoder_array
// Description : Multi-channel x4 quadrature decoder. Every raw pin is
//               synchronised (2 FF) and glitch-filtered; each channel keeps a
//               wrapping signed position count, a sticky illegal-transition
//               flag and a periodic velocity sample (shared period timer).
// Ports       : CLK        - system clock, rising edge
//               reset      - synchronous active-high reset
//               bus        - quad_encoder_array_if.slave (pins, count,
//                            velocity, vel_valid, error, A_filtered,
//                            optional index/index_seen)
// Options     : QUAD_INDEX_EN - adds filtered index input that zeroes the
//               count on its rising edge and sets a sticky index_seen flag.
// Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_array #(
    parameter int CHANNELS     = 2,
    parameter int COUNT_WIDTH  = 32,
    parameter int FILTER_DEPTH = 5,
    parameter int VEL_PERIOD   = 16000
) (
    input  logic                 CLK,
    input  logic                 reset,
    quad_encoder_array_if.slave  bus
);

`ifdef QUAD_INDEX_EN
    localparam int NIN = 3;
`else
    localparam int NIN = 2;
`endif
    localparam int NRAW = NIN * CHANNELS;

    localparam int             FCW       = 8;
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_DEPTH - 1);

    localparam int            WARM_CYCLES = FILTER_DEPTH + 3;
    localparam int            WW          = $clog2(WARM_CYCLES + 1);
    localparam logic [WW-1:0] WARM_DONE   = WW'(WARM_CYCLES);

    localparam int            PW          = $clog2(VEL_PERIOD);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(VEL_PERIOD - 1);

    // Raw pin vector layout: [A ch0..N-1][B ch0..N-1][index ch0..N-1]
    logic [NRAW-1:0] raw;
    logic [NRAW-1:0] filt;

`ifdef QUAD_INDEX_EN
    assign raw = {bus.index, bus.quadB, bus.quadA};
`else
    assign raw = {bus.quadB, bus.quadA};
`endif

    // ------------------------------------------------------------------
    // Synchroniser + stability filter, one per raw pin
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NRAW; i++) begin : g_in
        logic           meta;
        logic           sync;
        logic           filt_q;
        logic [FCW-1:0] fcnt;

        always_ff @(posedge CLK) begin
            if (reset) begin
                meta   <= 1'b0;
                sync   <= 1'b0;
                filt_q <= 1'b0;
                fcnt   <= '0;
            end else begin
                meta <= raw[i];
                sync <= meta;
                if (sync == filt_q) begin
                    fcnt <= '0;
                end else if (fcnt == FILT_LAST) begin
                    // FILTER_DEPTH consecutive differing cycles: accept
                    filt_q <= sync;
                    fcnt   <= '0;
                end else begin
                    fcnt <= fcnt + FCW'(1);
                end
            end
        end

        assign filt[i] = filt_q;
    end

    // ------------------------------------------------------------------
    // Warm-up: hold off decoding until the filters have settled on the
    // pin levels present at reset release.
    // ------------------------------------------------------------------
    logic [WW-1:0] warm_cnt;
    logic          decode_en;

    assign decode_en = (warm_cnt == WARM_DONE);

    always_ff @(posedge CLK) begin
        if (reset) begin
            warm_cnt <= '0;
        end else if (!decode_en) begin
            warm_cnt <= warm_cnt + WW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Shared velocity period timer
    // ------------------------------------------------------------------
    logic [PW-1:0] period_cnt;
    logic          period_last;
    logic          vel_valid_q;

    assign period_last = (period_cnt == PERIOD_LAST);

    always_ff @(posedge CLK) begin
        if (reset) begin
            period_cnt  <= '0;
            vel_valid_q <= 1'b0;
        end else begin
            period_cnt  <= period_last ? '0 : period_cnt + PW'(1);
            vel_valid_q <= period_last;
        end
    end

    assign bus.vel_valid  = vel_valid_q;
    assign bus.A_filtered = filt[CHANNELS-1:0];

    // ------------------------------------------------------------------
    // Per-channel decoder, counter, error flag and velocity sample
    // ------------------------------------------------------------------
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [1:0]             cur_ab;
        logic [1:0]             prev_ab;
        logic                   step_up;
        logic                   step_dn;
        logic                   illegal;
        logic                   idx_rise;
        logic [COUNT_WIDTH-1:0] cnt;
        logic [COUNT_WIDTH-1:0] snap;
        logic [COUNT_WIDTH-1:0] vel;
        logic                   err;

        assign cur_ab = {filt[c], filt[CHANNELS + c]};

        // {prev,cur} as {A,B,A,B}; forward order is 00->10->11->01->00
        always_comb begin
            step_up = 1'b0;
            step_dn = 1'b0;
            case ({prev_ab, cur_ab})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: step_up = 1'b1;
                4'b1000, 4'b1110, 4'b0111, 4'b0001: step_dn = 1'b1;
                default: ;
            endcase
        end

        assign illegal = ((prev_ab ^ cur_ab) == 2'b11);

`ifdef QUAD_INDEX_EN
        logic idx_prev;
        logic seen;

        assign idx_rise = filt[2*CHANNELS + c] & ~idx_prev;

        always_ff @(posedge CLK) begin
            if (reset) begin
                idx_prev <= 1'b0;
                seen     <= 1'b0;
            end else begin
                idx_prev <= filt[2*CHANNELS + c];
                if (decode_en && idx_rise) begin
                    seen <= 1'b1;
                end
            end
        end

        assign bus.index_seen[c] = seen;
`else
        assign idx_rise = 1'b0;
`endif

        always_ff @(posedge CLK) begin
            if (reset) begin
                prev_ab <= 2'b00;
                cnt     <= '0;
                snap    <= '0;
                vel     <= '0;
                err     <= 1'b0;
            end else begin
                // Tracks the filtered pins even during warm-up so the first
                // enabled comparison starts from the settled levels.
                prev_ab <= cur_ab;

                if (decode_en && idx_rise) begin
                    cnt <= '0;
                end else if (decode_en && step_up) begin
                    cnt <= cnt + COUNT_WIDTH'(1);
                end else if (decode_en && step_dn) begin
                    cnt <= cnt - COUNT_WIDTH'(1);
                end

                // A new illegal step outranks a simultaneous clear
                if (decode_en && illegal) begin
                    err <= 1'b1;
                end else if (bus.error_clear) begin
                    err <= 1'b0;
                end

                // Modular difference stays correct across count wrap
                if (period_last) begin
                    vel  <= cnt - snap;
                    snap <= cnt;
                end
            end
        end

        assign bus.count[c*COUNT_WIDTH +: COUNT_WIDTH]    = cnt;
        assign bus.velocity[c*COUNT_WIDTH +: COUNT_WIDTH] = vel;
        assign bus.error[c]                               = err;
    end

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_quad_encoder_array
// Description : Directed self-checking bench for quad_encoder_array.
//               8-bit counts keep signed wrap reachable in a short run;
//               VEL_PERIOD=100, FILTER_DEPTH=5, two channels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_array;

    localparam int CH = 2;
    localparam int CW = 8;
    localparam int FD = 5;
    localparam int VP = 100;

    logic CLK   = 1'b0;
    logic reset = 1'b1;

    always #5 CLK = ~CLK;

    quad_encoder_array_if #(.CHANNELS(CH), .COUNT_WIDTH(CW)) bus ();

    quad_encoder_array #(
        .CHANNELS    (CH),
        .COUNT_WIDTH (CW),
        .FILTER_DEPTH(FD),
        .VEL_PERIOD  (VP)
    ) dut (
        .CLK  (CLK),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    int tcount = 0;

    logic [1:0] ab_st [CH];

    typedef struct {
        int          ch;
        logic [1:0]  ab;
        logic [CW-1:0] exp0;
        logic [CW-1:0] exp1;
    } vec_t;

    vec_t vecs [8];

    task automatic tick();
        @(posedge CLK);
        #1;
        tcount++;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return bus.count[ch*CW +: CW];
    endfunction

    function automatic logic [CW-1:0] vel_of(input int ch);
        return bus.velocity[ch*CW +: CW];
    endfunction

    function automatic logic [1:0] next_fwd(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] next_rev(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic set_ab(input int ch, input logic [1:0] ab);
        ab_st[ch]       = ab;
        bus.quadA[ch]   = ab[1];
        bus.quadB[ch]   = ab[0];
    endtask

    initial begin
        int n;
        int t_last;
        int nstrobe;

        // {channel, new {A,B}, expected count0, expected count1}
        vecs[0] = '{ch:1, ab:2'b10, exp0:8'd32, exp1:8'd1};
        vecs[1] = '{ch:1, ab:2'b11, exp0:8'd32, exp1:8'd2};
        vecs[2] = '{ch:1, ab:2'b10, exp0:8'd32, exp1:8'd1};
        vecs[3] = '{ch:1, ab:2'b00, exp0:8'd32, exp1:8'd0};
        vecs[4] = '{ch:1, ab:2'b01, exp0:8'd32, exp1:8'hFF};
        vecs[5] = '{ch:0, ab:2'b01, exp0:8'd31, exp1:8'hFF};
        vecs[6] = '{ch:0, ab:2'b00, exp0:8'd32, exp1:8'hFF};
        vecs[7] = '{ch:1, ab:2'b00, exp0:8'd32, exp1:8'd0};

        bus.quadA       = '0;
        bus.quadB       = '0;
        bus.error_clear = 1'b0;
`ifdef QUAD_INDEX_EN
        bus.index       = '0;
`endif
        ab_st[0] = 2'b00;
        ab_st[1] = 2'b00;

        // ---------------- reset state ----------------
        reset = 1'b1;
        wait_cyc(3);
        check("rst_count",      32'(bus.count),      32'h0);
        check("rst_velocity",   32'(bus.velocity),   32'h0);
        check("rst_vel_valid",  32'(bus.vel_valid),  32'h0);
        check("rst_error",      32'(bus.error),      32'h0);
        check("rst_A_filtered", 32'(bus.A_filtered), 32'h0);
`ifdef QUAD_INDEX_EN
        check("rst_index_seen", 32'(bus.index_seen), 32'h0);
`endif
        reset = 1'b0;
        wait_cyc(20);

        // ---------------- 8 forward cycles on channel 0 ----------------
        for (int s = 0; s < 32; s++) begin
            set_ab(0, next_fwd(ab_st[0]));
            wait_cyc(20);
        end
        check("fwd8_count0", 32'(cnt_of(0)), 32'd32);
        check("fwd8_count1", 32'(cnt_of(1)), 32'd0);
        check("fwd8_error",  32'(bus.error), 32'h0);

        // ---------------- table of single steps ----------------
        for (int v = 0; v < 8; v++) begin
            set_ab(vecs[v].ch, vecs[v].ab);
            wait_cyc(12);
            check($sformatf("vec%0d_count0", v), 32'(cnt_of(0)), 32'(vecs[v].exp0));
            check($sformatf("vec%0d_count1", v), 32'(cnt_of(1)), 32'(vecs[v].exp1));
            check($sformatf("vec%0d_error", v),  32'(bus.error), 32'h0);
        end

        // ---------------- 3-cycle glitch rejected ----------------
        bus.quadA[1] = 1'b1;
        wait_cyc(3);
        bus.quadA[1] = 1'b0;
        wait_cyc(15);
        check("glitch_count1", 32'(cnt_of(1)), 32'd0);
        check("glitch_Afilt1", 32'(bus.A_filtered[1]), 32'd0);

        // ---------------- 5-cycle pulse accepted, exact latency ----------------
        set_ab(1, 2'b10);            // first sampled at the next edge (k)
        wait_cyc(5);                 // high for edges k..k+4
        set_ab(1, 2'b00);
        wait_cyc(2);                 // now past edge k+6
        check("lat_Afilt1_k6",  32'(bus.A_filtered[1]), 32'd1);
        check("lat_count1_k6",  32'(cnt_of(1)), 32'd0);
        tick();                      // past edge k+7
        check("lat_count1_k7",  32'(cnt_of(1)), 32'd1);
        wait_cyc(15);
        check("pulse_return_count1", 32'(cnt_of(1)), 32'd0);

        // ---------------- signed wrap ----------------
        for (int s = 0; s < 95; s++) begin
            set_ab(0, next_fwd(ab_st[0]));
            wait_cyc(8);
        end
        wait_cyc(10);
        check("pre_wrap_count0", 32'(cnt_of(0)), 32'h7F);
        set_ab(0, next_fwd(ab_st[0]));
        wait_cyc(12);
        check("wrap_up_count0", 32'(cnt_of(0)), 32'h80);
        set_ab(0, next_rev(ab_st[0]));
        wait_cyc(12);
        check("wrap_dn_count0", 32'(cnt_of(0)), 32'h7F);

        // ---------------- illegal steps and error clear ----------------
        set_ab(0, ab_st[0] ^ 2'b11);
        wait_cyc(12);
        check("illegal_error",  32'(bus.error), 32'h1);
        check("illegal_count0", 32'(cnt_of(0)), 32'h7F);
        set_ab(0, ab_st[0] ^ 2'b11);
        wait_cyc(7);                 // decoder sees the step on the next edge
        bus.error_clear = 1'b1;
        tick();
        bus.error_clear = 1'b0;
        check("set_wins_error", 32'(bus.error), 32'h1);
        wait_cyc(5);
        check("set_wins_count0", 32'(cnt_of(0)), 32'h7F);
        bus.error_clear = 1'b1;
        tick();
        bus.error_clear = 1'b0;
        check("clear_error", 32'(bus.error), 32'h0);

        // ---------------- mid-operation reset with pins at 11 ----------------
        set_ab(0, 2'b11);
        reset = 1'b1;
        wait_cyc(2);
        check("mid_rst_count",    32'(bus.count),      32'h0);
        check("mid_rst_velocity", 32'(bus.velocity),   32'h0);
        check("mid_rst_Afilt",    32'(bus.A_filtered), 32'h0);
        reset = 1'b0;
        n = 0;
        while (n < 300) begin
            tick();
            n++;
            if (n == 20) begin
                check("warmup_count0", 32'(cnt_of(0)),      32'h0);
                check("warmup_error",  32'(bus.error),      32'h0);
                check("warmup_Afilt",  32'(bus.A_filtered), 32'h1);
            end
            if (bus.vel_valid) break;
        end
        check("first_vel_valid_delay", 32'(n), 32'd100);
        t_last = tcount;

        // ---------------- velocity: forward 10 steps/period, crosses wrap ----------------
        nstrobe = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc % 10 == 0) set_ab(0, next_fwd(ab_st[0]));
            tick();
            if (bus.vel_valid) begin
                nstrobe++;
                check("vel_fwd_interval", 32'(tcount - t_last), 32'd100);
                t_last = tcount;
                if (nstrobe >= 2) check("vel_fwd_ch0", 32'(vel_of(0)), 32'd10);
                check("vel_fwd_ch1", 32'(vel_of(1)), 32'd0);
            end
        end
        check("vel_fwd_strobes", 32'(nstrobe), 32'd15);

        // ---------------- velocity: reverse ----------------
        nstrobe = 0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (cyc % 10 == 0) set_ab(0, next_rev(ab_st[0]));
            tick();
            if (bus.vel_valid) begin
                nstrobe++;
                check("vel_rev_interval", 32'(tcount - t_last), 32'd100);
                t_last = tcount;
                if (nstrobe >= 2) check("vel_rev_ch0", 32'(vel_of(0)), 32'hF6);
            end
        end
        check("vel_rev_strobes", 32'(nstrobe), 32'd5);
        wait_cyc(10);
        check("vel_end_count0", 32'(cnt_of(0)), 32'd100);

`ifdef QUAD_INDEX_EN
        // ---------------- index pulse with coincident step ----------------
        check("idx_seen_before", 32'(bus.index_seen), 32'h0);
        bus.index[0] = 1'b1;
        set_ab(0, next_fwd(ab_st[0]));
        wait_cyc(12);
        check("idx_count0", 32'(cnt_of(0)),      32'h0);
        check("idx_seen",   32'(bus.index_seen), 32'h1);
        bus.index[0] = 1'b0;
        wait_cyc(12);
        set_ab(0, next_fwd(ab_st[0]));
        wait_cyc(12);
        check("idx_after_step_count0", 32'(cnt_of(0)), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
